// File: rtl/phy_tx_pkg.sv
// Shared types, defaults and sizing helpers for the striped PHY transmitter.
package phy_tx_pkg;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

  // Counter width that is never zero.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  // Bytes carried by each lane per input word.
  function automatic int unsigned bpl(input int unsigned data_w, input int unsigned lanes);
    return data_w / (8 * lanes);
  endfunction

  // Cycles per word slot.
  function automatic int unsigned slot_len(input int unsigned data_w, input int unsigned lanes);
    return 8 * bpl(data_w, lanes);
  endfunction

endpackage

// File: rtl/phy_tx_lane_ser.sv
// One lane serialiser: parallel-load / shift-left register, MSB on the wire.
module phy_tx_lane_ser
  import phy_tx_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_32f,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         ser_out
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  // Load a fresh slot on the boundary, otherwise shift out the next bit.
  always_comb begin
    shreg_d = {shreg_q[W-2:0], 1'b0};
    if (load) shreg_d = load_data;
  end

  // Shift register state.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end

  assign ser_out = shreg_q[W-1];

endmodule

// File: rtl/phy_tx_lanes.sv
// Striped multi-lane PHY transmitter: valid/ready word input, bytes spread
// across LANES serial lanes, idle fill and a post-reset sync phase.
module phy_tx_lanes
  import phy_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LANES      = 2,
  parameter logic [7:0]  IDLE_SYM   = IDLE_SYM_DEFAULT,
  parameter int unsigned SYNC_WORDS = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [LANES-1:0]  lane_out,
  output logic              lane_data_valid,
  output logic              sym_start,
  output logic              sync_done
);

  localparam int unsigned BPL    = bpl(DATA_W, LANES);
  localparam int unsigned SLOT   = slot_len(DATA_W, LANES);
  localparam int unsigned SYM_W  = cnt_w(BPL);
  localparam int unsigned SYNC_W = cnt_w(SYNC_WORDS);
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(BPL - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  state_t            state_q, state_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              ldv_q, ldv_d;
  logic              sym_start_q, sym_start_d;

  logic              boundary;
  logic              accept;
  logic              send;
  logic [LANES-1:0][SLOT-1:0] load_data;

  // Bit/symbol counters stand in for the old divided clocks; the slot
  // boundary is the last bit of the last symbol of a lane slot.
  always_comb begin
    boundary    = (bit_cnt_q == 3'd7) && (sym_cnt_q == SYM_LAST);
    bit_cnt_d   = bit_cnt_q + 3'd1;
    sym_cnt_d   = sym_cnt_q;
    if (bit_cnt_q == 3'd7) begin
      sym_cnt_d = (sym_cnt_q == SYM_LAST) ? '0 : sym_cnt_q + 1'b1;
    end
    sym_start_d = (bit_cnt_d == 3'd0);
  end

  // Sync FSM: count idle slots after reset, then run forever.
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    if (state_q == ST_SYNC && boundary) begin
      if (sync_cnt_q == SYNC_LAST) state_d    = ST_RUN;
      else                         sync_cnt_d = sync_cnt_q + 1'b1;
    end
  end

  assign in_ready  = (state_q == ST_RUN) && !hold_valid_q;
  assign sync_done = (state_q == ST_RUN);

  // One-deep holding register and data-valid flag for the next slot.
  always_comb begin
    accept       = in_valid && in_ready;
    send         = boundary && (state_q == ST_RUN) && hold_valid_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (send) hold_valid_d = 1'b0;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
    end
    ldv_d = ldv_q;
    if (boundary) ldv_d = send;
  end

  // Byte i of the word becomes symbol i/LANES of lane i%LANES.
  always_comb begin
    load_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      for (int unsigned j = 0; j < BPL; j++) begin
        if (send) load_data[k][SLOT-1-8*j -: 8] = hold_data_q[DATA_W-1-8*(j*LANES+k) -: 8];
        else      load_data[k][SLOT-1-8*j -: 8] = IDLE_SYM;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      bit_cnt_q    <= 3'd7;
      sym_cnt_q    <= SYM_LAST;
      sync_cnt_q   <= '0;
      state_q      <= ST_SYNC;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      ldv_q        <= 1'b0;
      sym_start_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      ldv_q        <= ldv_d;
      sym_start_q  <= sym_start_d;
    end
  end

  assign lane_data_valid = ldv_q;
  assign sym_start       = sym_start_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    phy_tx_lane_ser #(.W(SLOT)) u_ser (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .load      (boundary),
      .load_data (load_data[k]),
      .ser_out   (lane_out[k])
    );
  end

endmodule

// File: tb/tb_phy_tx_lanes.sv
// Directed self-checking bench for phy_tx_lanes (2-lane and 4-lane builds).
module tb_phy_tx_lanes;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [1:0]  lane_out;
  logic        ldv;
  logic        sym_start;
  logic        sync_done;

  logic        in_valid4;
  logic [31:0] in_data4;
  logic        in_ready4;
  logic [3:0]  lane_out4;
  logic        ldv4;
  logic        sym_start4;
  logic        sync_done4;

  int n_assert = 0;
  int n_fail   = 0;

  phy_tx_lanes #(.DATA_W(32), .LANES(2), .IDLE_SYM(8'hBC), .SYNC_WORDS(4)) dut (
    .clk_32f(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .lane_out(lane_out), .lane_data_valid(ldv),
    .sym_start(sym_start), .sync_done(sync_done)
  );

  phy_tx_lanes #(.DATA_W(32), .LANES(4), .IDLE_SYM(8'hBC), .SYNC_WORDS(4)) dut4 (
    .clk_32f(clk), .reset(reset), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .lane_out(lane_out4), .lane_data_valid(ldv4),
    .sym_start(sym_start4), .sync_done(sync_done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp0 [0:11];
  logic [15:0] exp1 [0:11];
  logic [7:0]  bytes4 [0:3];
  logic [7:0]  idle_b;
  logic [3:0]  e4;
  int s, b, s4, b4;

  initial begin
    for (int i = 0; i < 12; i++) begin
      exp0[i] = 16'hBCBC;
      exp1[i] = 16'hBCBC;
    end
    exp0[4]  = 16'hA1C3; exp1[4]  = 16'hB2D4;
    exp0[6]  = 16'h0103; exp1[6]  = 16'h0204;
    exp0[7]  = 16'hFF00; exp1[7]  = 16'hEE11;
    exp0[10] = 16'h139B; exp1[10] = 16'h57DF;
    exp0[11] = 16'h24AC; exp1[11] = 16'h68E0;
    bytes4[0] = 8'hA1; bytes4[1] = 8'hB2; bytes4[2] = 8'hC3; bytes4[3] = 8'hD4;
    idle_b = 8'hBC;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_valid4 = 1'b0;
    in_data4  = 32'h0;
    tick();
    tick();
    chk("rst lane_out", 32'(lane_out), 32'h0);
    chk("rst ldv", 32'(ldv), 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'h0);
    chk("rst sync_done", 32'(sync_done), 32'h0);
    chk("rst sym_start", 32'(sym_start), 32'h0);
    chk("rst4 lane_out", 32'(lane_out4), 32'h0);
    chk("rst4 in_ready", 32'(in_ready4), 32'h0);

    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA1B2C3D4;
    in_valid4 = 1'b1;
    in_data4  = 32'hA1B2C3D4;

    // Cycle c is the cycle following the c-th clock edge after reset release.
    for (int c = 1; c <= 182; c++) begin
      tick();
      s = (c - 1) / 16;
      b = 15 - (c - 1) % 16;
      chk($sformatf("lane0 c%0d", c), 32'(lane_out[0]), 32'(exp0[s][b]));
      chk($sformatf("lane1 c%0d", c), 32'(lane_out[1]), 32'(exp1[s][b]));
      chk($sformatf("ldv c%0d", c), 32'(ldv),
          32'(s == 4 || s == 6 || s == 7 || s == 10 || s == 11));
      chk($sformatf("in_ready c%0d", c), 32'(in_ready),
          32'(c == 49 || (c >= 65 && c <= 81) || c == 97 || (c >= 113 && c <= 144) ||
              c == 161 || c == 177));
      chk($sformatf("sync_done c%0d", c), 32'(sync_done), 32'(c >= 49));
      chk($sformatf("sym_start c%0d", c), 32'(sym_start), 32'((c - 1) % 8 == 0));
      if (c <= 48) begin
        s4 = (c - 1) / 8;
        b4 = 7 - (c - 1) % 8;
        for (int k = 0; k < 4; k++) e4[k] = (s4 == 4) ? bytes4[k][b4] : idle_b[b4];
        chk($sformatf("lane4 c%0d", c), 32'(lane_out4), 32'(e4));
        chk($sformatf("ldv4 c%0d", c), 32'(ldv4), 32'(s4 == 4));
        chk($sformatf("in_ready4 c%0d", c), 32'(in_ready4), 32'(c == 25 || c >= 33));
        chk($sformatf("sym_start4 c%0d", c), 32'(sym_start4), 32'((c - 1) % 8 == 0));
      end
      case (c)
        26:  in_valid4 = 1'b0;
        50:  in_valid  = 1'b0;
        52:  begin in_valid = 1'b1; in_data = 32'h55555555; end
        53:  in_valid  = 1'b0;
        81:  begin in_valid = 1'b1; in_data = 32'h01020304; end
        82:  in_data   = 32'hFFEE0011;
        98:  begin in_valid = 1'b0; in_data = 32'hDEADBEEF; end
        144: begin in_valid = 1'b1; in_data = 32'h13579BDF; end
        145: in_valid  = 1'b0;
        161: begin in_valid = 1'b1; in_data = 32'h2468ACE0; end
        162: in_valid  = 1'b0;
        177: begin in_valid = 1'b1; in_data = 32'h0F0F0F0F; end
        178: in_valid  = 1'b0;
        default: ;
      endcase
    end

    // Reset lands mid-slot with a word still held.
    reset = 1'b1;
    #1;
    chk("midrst lane_out", 32'(lane_out), 32'h0);
    chk("midrst ldv", 32'(ldv), 32'h0);
    chk("midrst in_ready", 32'(in_ready), 32'h0);
    chk("midrst sync_done", 32'(sync_done), 32'h0);
    chk("midrst sym_start", 32'(sym_start), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    for (int c = 1; c <= 80; c++) begin
      tick();
      b4 = 7 - (c - 1) % 8;
      chk($sformatf("re lanes c%0d", c), 32'(lane_out), 32'({2{idle_b[b4]}}));
      chk($sformatf("re ldv c%0d", c), 32'(ldv), 32'h0);
      chk($sformatf("re in_ready c%0d", c), 32'(in_ready), 32'(c >= 49));
      chk($sformatf("re sync_done c%0d", c), 32'(sync_done), 32'(c >= 49));
      chk($sformatf("re sym_start c%0d", c), 32'(sym_start), 32'((c - 1) % 8 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
